// File: rtl/sm83_pkg.sv
// sm83_pkg: shared SM83 register-file types, write strobes and helpers.
package sm83_pkg;

    typedef logic [8:0] r8_t;

    typedef enum logic [2:0] {R8_B, R8_C, R8_D, R8_E, R8_H, R8_L} gp_r8_sel_t;
    typedef enum logic [1:0] {R16_BC, R16_DE, R16_HL} gp_r16_sel_t;
    typedef enum logic [2:0] {T16_BC, T16_DE, T16_HL, T16_PC, T16_SP} r16_tgt_t;
    typedef enum logic {IDU_INC, IDU_DEC} idu_op_t;

    typedef struct packed {
        logic ir, ie, a, f, gp8, gp16, pc, sp;
    } reg_wen_vec_t;

    typedef struct packed {
        r8_t ir, ie, a, f, b, c, d, e, h, l;
        logic [15:0] pc, sp;
    } reg_vec_t;

    localparam logic [7:0] F_MASK = 8'hF0;

    function automatic logic [15:0] pick16(input r16_tgt_t t, input logic [15:0] bc,
                                           input logic [15:0] de, input logic [15:0] hl,
                                           input logic [15:0] pc, input logic [15:0] sp);
        return t == T16_BC ? bc : t == T16_DE ? de : t == T16_HL ? hl :
               t == T16_PC ? pc : t == T16_SP ? sp : 16'h0000;
    endfunction

endpackage

// File: rtl/sm83_idu.sv
// sm83_idu: combinational 16-bit increment/decrement, wraps modulo 2^16.
module sm83_idu
    import sm83_pkg::*;
(
    input  logic [15:0] in,
    input  idu_op_t     op,
    output logic [15:0] out
);

    assign out = op == IDU_INC ? in + 16'd1 : in - 16'd1;

endmodule

// File: rtl/sm83_regfile.sv
// sm83_regfile: SM83 architectural registers with write-strobe muxing and the IDU.
// Explicit writes beat IDU writes; a dropped IDU write is flagged one cycle later.
module sm83_regfile
    import sm83_pkg::*;
#(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter logic [15:0] SP_RESET = 16'hFFFE
) (
    input  logic         clk,
    input  logic         rst,
    input  reg_wen_vec_t wen,
    input  gp_r8_sel_t   wr_sel8,
    input  gp_r16_sel_t  wr_sel16,
    input  logic [7:0]   wr_data8,
    input  logic [15:0]  wr_data16,
    input  logic         idu_req,
    input  idu_op_t      idu_op,
    input  r16_tgt_t     idu_tgt,
    output logic [15:0]  idu_out,
    output logic         idu_clash,
    input  gp_r8_sel_t   rd_sel8,
    output logic [7:0]   rd_data8,
    input  r16_tgt_t     rd_sel16,
    output logic [15:0]  rd_data16,
    output reg_vec_t     regs
);

    // gp bytes ordered B,C,D,E,H,L so pair p is bytes {2p, 2p+1}
    logic [7:0]  gp_q [6];
    logic [7:0]  gp_d [6];
    logic [7:0]  ir_q, ir_d, ie_q, ie_d, a_q, a_d, f_q, f_d;
    logic [15:0] pc_q, pc_d, sp_q, sp_d;
    logic        clash_q, clash_d;
    logic [15:0] bc, de, hl, idu_in;
    logic [2:0]  gp16_hit;
    logic [5:0]  gp8_hit;
    logic [3:0]  pair_wen;
    logic        idu_we;

    assign bc = {gp_q[0], gp_q[1]};
    assign de = {gp_q[2], gp_q[3]};
    assign hl = {gp_q[4], gp_q[5]};
    assign idu_in = pick16(idu_tgt, bc, de, hl, pc_q, sp_q);

    sm83_idu u_idu (
        .in  (idu_in),
        .op  (idu_op),
        .out (idu_out)
    );

    always_comb begin
        for (int p = 0; p < 3; p++) gp16_hit[p] = wen.gp16 && int'(wr_sel16) == p;
        for (int i = 0; i < 6; i++) gp8_hit[i] = wen.gp8 && int'(wr_sel8) == i;
        pair_wen[3] = 1'b0;
        for (int p = 0; p < 3; p++) pair_wen[p] = gp16_hit[p] | gp8_hit[2*p] | gp8_hit[2*p+1];
        clash_d = idu_req && ((idu_tgt == T16_PC && wen.pc) || (idu_tgt == T16_SP && wen.sp) ||
                              (int'(idu_tgt) < 3 && pair_wen[idu_tgt[1:0]]));
        idu_we = idu_req && !clash_d;
        for (int i = 0; i < 6; i++)
            gp_d[i] = gp16_hit[i/2] ? (i[0] ? wr_data16[7:0] : wr_data16[15:8]) :
                      gp8_hit[i] ? wr_data8 :
                      (idu_we && int'(idu_tgt) == i/2) ? (i[0] ? idu_out[7:0] : idu_out[15:8]) :
                      gp_q[i];
        ir_d = wen.ir ? wr_data8 : ir_q;
        ie_d = wen.ie ? wr_data8 : ie_q;
        a_d  = wen.a ? wr_data8 : a_q;
        f_d  = wen.f ? wr_data8 & F_MASK : f_q;
        pc_d = wen.pc ? wr_data16 : (idu_we && idu_tgt == T16_PC) ? idu_out : pc_q;
        sp_d = wen.sp ? wr_data16 : (idu_we && idu_tgt == T16_SP) ? idu_out : sp_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) gp_q[i] <= '0;
            ir_q    <= '0;
            ie_q    <= '0;
            a_q     <= '0;
            f_q     <= '0;
            pc_q    <= PC_RESET;
            sp_q    <= SP_RESET;
            clash_q <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) gp_q[i] <= gp_d[i];
            ir_q    <= ir_d;
            ie_q    <= ie_d;
            a_q     <= a_d;
            f_q     <= f_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            clash_q <= clash_d;
        end
    end

    assign idu_clash = clash_q;
    assign rd_data8  = int'(rd_sel8) < 6 ? gp_q[rd_sel8] : 8'h00;
    assign rd_data16 = pick16(rd_sel16, bc, de, hl, pc_q, sp_q);

    assign regs = '{ir: {1'b0, ir_q}, ie: {1'b0, ie_q}, a: {1'b0, a_q}, f: {1'b0, f_q & F_MASK},
                    b: {1'b0, gp_q[0]}, c: {1'b0, gp_q[1]}, d: {1'b0, gp_q[2]},
                    e: {1'b0, gp_q[3]}, h: {1'b0, gp_q[4]}, l: {1'b0, gp_q[5]},
                    pc: pc_q, sp: sp_q};

endmodule

// File: tb/tb_sm83_regfile.sv
// tb_sm83_regfile: directed vectors for sm83_regfile with hand-computed expectations.
module tb_sm83_regfile;
    import sm83_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    reg_wen_vec_t wen;
    gp_r8_sel_t   wr_sel8, rd_sel8;
    gp_r16_sel_t  wr_sel16;
    logic [7:0]   wr_data8, rd_data8;
    logic [15:0]  wr_data16, rd_data16, idu_out;
    logic         idu_req, idu_clash;
    idu_op_t      idu_op;
    r16_tgt_t     idu_tgt, rd_sel16;
    reg_vec_t     regs;
    int           n_tests = 0;
    int           n_fail = 0;

    sm83_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .wen       (wen),
        .wr_sel8   (wr_sel8),
        .wr_sel16  (wr_sel16),
        .wr_data8  (wr_data8),
        .wr_data16 (wr_data16),
        .idu_req   (idu_req),
        .idu_op    (idu_op),
        .idu_tgt   (idu_tgt),
        .idu_out   (idu_out),
        .idu_clash (idu_clash),
        .rd_sel8   (rd_sel8),
        .rd_data8  (rd_data8),
        .rd_sel16  (rd_sel16),
        .rd_data16 (rd_data16),
        .regs      (regs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wen = '0;
        idu_req = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        wr_sel8 = R8_B;
        wr_sel16 = R16_BC;
        wr_data8 = '0;
        wr_data16 = '0;
        idu_op = IDU_INC;
        idu_tgt = T16_PC;
        rd_sel8 = R8_B;
        rd_sel16 = T16_PC;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_ir", regs.ir, 0);
        check("rst_a", regs.a, 0);
        check("rst_f", regs.f, 0);
        check("rst_hl", {regs.h, regs.l}, 0);
        check("rst_pc", regs.pc, 16'h0000);
        check("rst_sp", regs.sp, 16'hFFFE);
        check("rst_clash", idu_clash, 0);

        wen.f = 1'b1; wr_data8 = 8'hFF;
        tick(); idle();
        check("f_mask", regs.f, 9'h0F0);
        wen.gp8 = 1'b1; wr_sel8 = R8_C; wr_data8 = 8'h5A; rd_sel8 = R8_C;
        #1 check("c_same_cycle", rd_data8, 8'h00);
        tick(); idle();
        check("c_read", rd_data8, 8'h5A);
        check("c_snap", regs.c, 9'h05A);
        wen.gp8 = 1'b1; wr_sel8 = gp_r8_sel_t'(3'd6); wr_data8 = 8'h77;
        rd_sel8 = gp_r8_sel_t'(3'd6); rd_sel16 = r16_tgt_t'(3'd5);
        tick(); idle();
        check("r8_inval_rd", rd_data8, 8'h00);
        check("r16_inval_rd", rd_data16, 16'h0000);
        check("r8_inval_wr", {regs.b, regs.c, regs.d, regs.e, regs.h, regs.l}, {9'h000, 9'h05A, 36'h0});

        wen.sp = 1'b1; wr_data16 = 16'h0000;
        tick(); idle();
        idu_req = 1'b1; idu_op = IDU_DEC; idu_tgt = T16_SP;
        #1 check("idu_out_dec", idu_out, 16'hFFFF);
        tick(); idle();
        check("sp_wrap", regs.sp, 16'hFFFF);
        wen.gp16 = 1'b1; wr_sel16 = R16_HL; wr_data16 = 16'hFFFF;
        tick(); idle();
        idu_req = 1'b1; idu_op = IDU_INC; idu_tgt = T16_HL; rd_sel16 = T16_HL;
        tick(); idle();
        check("hl_wrap", rd_data16, 16'h0000);
        wen.pc = 1'b1; wr_data16 = 16'h0100;
        tick(); idle();
        rd_sel16 = T16_PC;
        idu_req = 1'b1; idu_op = IDU_INC; idu_tgt = T16_PC;
        repeat (3) tick();
        idle();
        check("pc_chain", rd_data16, 16'h0103);

        wen.pc = 1'b1; wr_data16 = 16'h1234; idu_req = 1'b1; idu_op = IDU_INC; idu_tgt = T16_PC;
        tick(); idle();
        check("clash_pc", regs.pc, 16'h1234);
        check("clash_flag", idu_clash, 1);
        wen.a = 1'b1; wr_data8 = 8'h3C; idu_req = 1'b1;
        tick(); idle();
        check("noclash_pc", regs.pc, 16'h1235);
        check("noclash_a", regs.a, 9'h03C);
        check("noclash_flag", idu_clash, 0);

        wen.gp16 = 1'b1; wr_sel16 = R16_DE; wr_data16 = 16'hBEEF;
        wen.gp8 = 1'b1; wr_sel8 = R8_E; wr_data8 = 8'h11; rd_sel16 = T16_DE;
        tick(); idle();
        check("de_gp16_wins", rd_data16, 16'hBEEF);
        wen.gp16 = 1'b1; wr_sel16 = R16_BC; wr_data16 = 16'hCAFE;
        wen.gp8 = 1'b1; wr_sel8 = R8_H; wr_data8 = 8'h22; rd_sel16 = T16_BC; rd_sel8 = R8_H;
        tick(); idle();
        check("bc_both", rd_data16, 16'hCAFE);
        check("h_both", rd_data8, 8'h22);

        wen.sp = 1'b1; wr_data16 = 16'h4000; idu_req = 1'b1; idu_tgt = T16_SP;
        tick(); idle();
        check("clash_sp", idu_clash, 1);
        rst = 1'b1; wen.gp16 = 1'b1; wr_sel16 = R16_HL; wr_data16 = 16'hAAAA;
        idu_req = 1'b1; idu_tgt = T16_PC;
        tick(); idle();
        rst = 1'b0;
        check("rst2_pc", regs.pc, 16'h0000);
        check("rst2_sp", regs.sp, 16'hFFFE);
        check("rst2_hl", {regs.h, regs.l}, 0);
        check("rst2_bc", {regs.b, regs.c}, 0);
        check("rst2_a", regs.a, 0);
        check("rst2_clash", idu_clash, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
